// File: rtl/bridge_pkg.sv
// Shared constants and helpers for the bridge output encoder.
// Covers the word width, the event field layout and the scan state encoding.
package bridge_pkg;

    localparam int Y_W   = 42;
    localparam int IDX_W = 6;
    localparam int EV_W  = 16;

    localparam int EV_LAST   = 15;
    localparam int EV_SEQ_HI = 14;
    localparam int EV_SEQ_LO = 7;
    localparam int EV_LVL    = 6;
    localparam int EV_IDX_HI = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic logic [EV_W-1:0] ev_pack(
        input logic             last,
        input logic [7:0]       seq,
        input logic             lvl,
        input logic [IDX_W-1:0] idx
    );
        logic [EV_W-1:0] v;
        v                       = '0;
        v[EV_LAST]              = last;
        v[EV_SEQ_HI:EV_SEQ_LO]  = seq;
        v[EV_LVL]               = lvl;
        v[EV_IDX_HI:0]          = idx;
        return v;
    endfunction

endpackage

// File: rtl/bridge_evt_fifo.sv
// Show-ahead synchronous FIFO for change events.
// A push is accepted on a full FIFO when a pop happens in the same cycle.
module bridge_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Gate the head with empty so the output reads zero out of reset.
    assign o_data = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push)
                r_wr <= r_wr + AW'(1);
            if (w_do_pop)
                r_rd <= r_rd + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bridge_out_encoder.sv
// Turns bit changes of the bridge FSM output word into a stream of per-bit events.
// Strobes that arrive during a scan wait in a single pending slot.
module bridge_out_encoder #(
    parameter int Y_W   = bridge_pkg::Y_W,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [Y_W-1:0] y_in,
    input  logic           y_stb,
    input  logic           ev_ready,
    output logic           ev_valid,
    output logic [15:0]    ev_data,
    input  logic           ovr_clr,
    output logic           overrun,
    output logic           busy
);

    import bridge_pkg::*;

    state_t           r_state;
    logic [Y_W-1:0]   r_base;
    logic [Y_W-1:0]   r_mask;
    logic [Y_W-1:0]   r_pend_word;
    logic             r_pend_vld;
    logic [7:0]       r_seq;
    logic             r_ovr;

    logic [Y_W-1:0]   w_word;
    logic [Y_W-1:0]   w_diff;
    logic [Y_W-1:0]   w_mask_nxt;
    logic [IDX_W-1:0] w_idx;
    logic             w_last;
    logic             w_start;
    logic             w_ovr_set;
    logic             w_pop;
    logic             w_push;
    logic             w_can_push;
    logic             w_full;
    logic             w_empty;
    logic [EV_W-1:0]  w_ev;

    // A held snapshot is older than a strobe arriving now, so it goes first.
    assign w_word  = r_pend_vld ? r_pend_word : y_in;
    assign w_diff  = w_word ^ r_base;
    assign w_start = (r_state == ST_IDLE) && (r_pend_vld || y_stb);

    assign w_ovr_set = y_stb && r_pend_vld && (r_state == ST_SCAN);

    always_comb begin
        w_idx = '0;
        for (int i = Y_W - 1; i >= 0; i--)
            if (r_mask[i])
                w_idx = IDX_W'(i);
    end

    assign w_mask_nxt = r_mask & (r_mask - Y_W'(1));
    assign w_last     = (w_mask_nxt == '0);
    assign w_ev       = ev_pack(w_last, r_seq, r_base[w_idx], w_idx);

    assign w_pop      = ev_valid && ev_ready;
    assign w_can_push = !w_full || w_pop;
    assign w_push     = (r_state == ST_SCAN) && w_can_push;

    bridge_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (w_ev),
        .i_pop   (w_pop),
        .o_data  (ev_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign ev_valid = !w_empty;
    assign overrun  = r_ovr;
    assign busy     = (r_state == ST_SCAN) || r_pend_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_mask      <= '0;
            r_pend_word <= '0;
            r_pend_vld  <= 1'b0;
            r_seq       <= '0;
            r_ovr       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_base <= w_word;
                        if (w_diff != '0) begin
                            r_mask  <= w_diff;
                            r_state <= ST_SCAN;
                        end
                    end
                    if (r_pend_vld) begin
                        r_pend_vld <= y_stb;
                        if (y_stb)
                            r_pend_word <= y_in;
                    end
                end
                ST_SCAN: begin
                    if (w_push) begin
                        r_mask <= w_mask_nxt;
                        if (w_last) begin
                            r_seq   <= r_seq + 8'd1;
                            r_state <= ST_IDLE;
                        end
                    end
                    if (y_stb) begin
                        r_pend_vld  <= 1'b1;
                        r_pend_word <= y_in;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_ovr_set)
                r_ovr <= 1'b1;
            else if (ovr_clr)
                r_ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bridge_out_encoder.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_bridge_out_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [41:0] y_in = '0;
    logic        y_stb = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ev_valid;
    logic [15:0] ev_data;
    logic        ovr_clr = 1'b0;
    logic        overrun;
    logic        busy;

    int nchk = 0;
    int nerr = 0;
    logic [15:0] q[$];

    bridge_out_encoder #(.Y_W(42), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .y_in     (y_in),
        .y_stb    (y_stb),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ovr_clr  (ovr_clr),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // {last, seq[7:0], level, idx[5:0]}
    function automatic logic [15:0] ev(input logic last, input int seq, input logic lvl, input int idx);
        logic [7:0] s;
        logic [5:0] ix;
        s  = seq[7:0];
        ix = idx[5:0];
        return {last, s, lvl, ix};
    endfunction

    function automatic logic [41:0] bit42(input int i);
        logic [41:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [41:0] w);
        y_in  = w;
        y_stb = 1'b1;
        tick();
        y_stb = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(q.size() == 0 && !busy && !ev_valid) && n < 300) begin
            tick();
            n++;
        end
        nchk++;
        if (n >= 300) begin
            nerr++;
            $display("FAIL %s drain timeout: %0d events still expected", name, q.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst && ev_valid && ev_ready) begin
            nchk++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected event: got 0x%04h expected none", ev_data);
            end else begin
                logic [15:0] e;
                e = q.pop_front();
                if (ev_data !== e) begin
                    nerr++;
                    $display("FAIL event: got 0x%04h expected 0x%04h", ev_data, e);
                end
            end
        end
    end

    initial begin
        logic [41:0] w0;
        logic [41:0] w3;
        logic [15:0] hold;

        #1;
        check("reset ev_valid", {15'd0, ev_valid}, 16'd0);
        check("reset ev_data", ev_data, 16'd0);
        check("reset overrun", {15'd0, overrun}, 16'd0);
        check("reset busy", {15'd0, busy}, 16'd0);
        tick();
        rst = 1'b1;
        ev_ready = 1'b1;
        tick();

        // 1: unchanged word produces nothing
        strobe('0);
        check("t1 busy", {15'd0, busy}, 16'd0);
        tick();
        check("t1 ev_valid", {15'd0, ev_valid}, 16'd0);

        // 2: three bits rise, first event two cycles after the strobe
        q.push_back(16'h0060);
        q.push_back(16'h0061);
        q.push_back(16'h8062);
        strobe(42'h7 << 32);
        check("t2 lat N+1", {15'd0, ev_valid}, 16'd0);
        tick();
        check("t2 lat N+2", {15'd0, ev_valid}, 16'd1);
        wait_drain("t2");

        // 3: bit 32 falls, seq now 1
        q.push_back(16'h80A0);
        strobe(42'h6 << 32);
        wait_drain("t3");

        // 4: 11-bit change against a stalled consumer
        ev_ready = 1'b0;
        for (int i = 0; i < 11; i++)
            q.push_back(ev(i == 10, 2, 1'b1, i));
        strobe((42'h6 << 32) | 42'h7FF);
        repeat (15) tick();
        check("t4 busy stalled", {15'd0, busy}, 16'd1);
        check("t4 head", ev_data, ev(1'b0, 2, 1'b1, 0));
        hold = ev_data;
        tick();
        check("t4 head stable", ev_data, hold);
        ev_ready = 1'b1;
        wait_drain("t4");

        // 5: three strobes during a stalled scan, only the last survives
        ev_ready = 1'b0;
        w0 = (42'h6 << 32) | 42'h400;
        for (int i = 0; i < 10; i++)
            q.push_back(ev(i == 9, 3, 1'b0, i));
        strobe(w0);
        repeat (12) tick();
        strobe(w0 | bit42(20));
        tick();
        strobe(w0 | bit42(21));
        tick();
        w3 = w0 | bit42(40);
        strobe(w3);
        check("t5 overrun set", {15'd0, overrun}, 16'd1);
        check("t5 busy", {15'd0, busy}, 16'd1);
        q.push_back(ev(1'b1, 4, 1'b1, 40));
        ev_ready = 1'b1;
        wait_drain("t5");
        check("t5 overrun sticky", {15'd0, overrun}, 16'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("t5 overrun cleared", {15'd0, overrun}, 16'd0);

        // 6: reset mid-scan wipes queue, baseline and seq
        ev_ready = 1'b0;
        strobe(w3 ^ 42'hFFF);
        repeat (12) tick();
        check("t6 busy before rst", {15'd0, busy}, 16'd1);
        check("t6 valid before rst", {15'd0, ev_valid}, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6 rst ev_valid", {15'd0, ev_valid}, 16'd0);
        check("t6 rst busy", {15'd0, busy}, 16'd0);
        check("t6 rst ev_data", ev_data, 16'd0);
        tick();
        rst = 1'b1;
        ev_ready = 1'b1;
        tick();
        q.push_back(ev(1'b0, 0, 1'b1, 1));
        q.push_back(ev(1'b1, 0, 1'b1, 2));
        strobe(42'h6);
        wait_drain("t6");

        check("final queue empty", 16'(q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
